// File: rtl/inst_prefetch_queue_if.sv
// Bus bundle between the instruction prefetch queue, the instruction SRAM
// and the CPU fetch stage. The master side is the queue itself; the slave
// side is the environment (IM + fetch stage) that feeds and drains it.
interface inst_prefetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int IM_AW = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_rdata;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             deq_ready;
    logic             inst_valid;
    logic [31:0]      inst;
    logic [31:0]      inst_pc;
    logic [CNT_W-1:0] count;

    modport master (
        output im_addr,
        output inst_valid,
        output inst,
        output inst_pc,
        output count,
        input  im_rdata,
        input  redirect,
        input  redirect_pc,
        input  deq_ready
    );

    modport slave (
        input  im_addr,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  count,
        output im_rdata,
        output redirect,
        output redirect_pc,
        output deq_ready
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetch addresses to a
// 1-cycle-latency instruction SRAM, buffers up to DEPTH {pc, inst} entries
// and hands them to the CPU through a valid/ready handshake. A redirect
// flushes everything and restarts fetch at a new word-aligned PC.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 16
) (
    input logic                   clk,
    input logic                   rst,
    inst_prefetch_queue_if.master bus
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    // Control state
    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             inflight;

    // Data state (never needs reset; qualified by count/inflight)
    logic [31:0]      inflight_pc;
    logic [31:0]      mem_pc   [DEPTH];
    logic [31:0]      mem_inst [DEPTH];

    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             enq;
    logic             deq;
    logic             head_valid;

    // Only the word-aligned part of the redirect target is meaningful.
    logic             unused_redirect_lsb;
    assign unused_redirect_lsb = &{1'b0, bus.redirect_pc[1:0]};

    // Issue/enqueue/dequeue decisions for this cycle; redirect overrides all.
    always_comb begin
        occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight};
        head_valid = (count_q != '0);
        // The dequeue happening this cycle is not credited back, so a
        // response can never arrive into a full queue.
        issue      = !bus.redirect && (occupancy < DEPTH_C);
        enq        = inflight && !bus.redirect;
        deq        = head_valid && bus.deq_ready && !bus.redirect;
    end

    // Fetch PC, in-flight flag, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
        end else if (bus.redirect) begin
            // The response for whatever was issued last cycle is dropped by
            // clearing inflight here.
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag register for the outstanding read and the entry storage.
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= fetch_pc;
        end
        if (enq) begin
            mem_pc[wr_ptr]   <= inflight_pc;
            mem_inst[wr_ptr] <= bus.im_rdata;
        end
    end

    // Head of queue and IM address are presented combinationally.
    always_comb begin
        bus.im_addr    = fetch_pc[IM_AW-1:0];
        bus.count      = count_q;
        bus.inst_valid = head_valid;
        bus.inst       = NOP;
        bus.inst_pc    = 32'h0000_0000;
        if (head_valid) begin
            bus.inst    = mem_inst[rd_ptr];
            bus.inst_pc = mem_pc[rd_ptr];
        end
    end
endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Instruction prefetch queue between the instruction SRAM (IM) and the CPU fetch stage. Generates sequential fetch addresses, absorbs the IM's 1-cycle read latency, and buffers up to DEPTH fetched instructions tagged with their PC. The CPU consumes them through a valid/ready handshake and redirects the fetch stream on taken branches and jumps.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- IM_AW, 16: IM address width; IM is byte-addressed.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low (rst=0 resets).
- im_addr  output  IM_AW  IM read address, equal to fetch_pc[IM_AW-1:0].
- im_rdata  input  32  IM read data; valid the cycle after the address is presented.
- redirect  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- deq_ready  input  1  CPU fetch stage accepts the head entry this cycle.
- inst_valid  output  1  head entry is valid.
- inst  output  32  head instruction; 32'h0000_0013 (NOP) when inst_valid=0.
- inst_pc  output  32  head PC; 0 when inst_valid=0.
- count  output  $clog2(DEPTH+1)  number of valid entries.

## Operation
- State: fetch_pc (32b), circular storage of DEPTH entries {pc, inst}, rd_ptr/wr_ptr (mod DEPTH), count, inflight (1b), inflight_pc (32b).
- Issue condition: issue = !redirect && (count + inflight < DEPTH). The dequeue in the current cycle is not credited, which is conservative.
- On issue: inflight←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+4. fetch_pc wraps modulo 2^32.
- Without issue: im_addr still equals fetch_pc. IM reads are side-effect free. inflight←0.
- Response: when inflight=1 and no redirect, write {inflight_pc, im_rdata} at wr_ptr and increment wr_ptr. The credit rule guarantees the queue is never full at this point.
- Dequeue: occurs when inst_valid && deq_ready && !redirect. rd_ptr increments.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- No bypass: a response arriving with count=0 becomes visible next cycle.
- Redirect, which has highest priority:
  - count←0, rd_ptr←wr_ptr←0, inflight←0. The response arriving next cycle is discarded.
  - fetch_pc←{redirect_pc[31:2],2'b00}. No issue in the redirect cycle.
  - A dequeue handshake in the redirect cycle is not performed; the CPU must treat that head as flushed.
- Outputs inst, inst_pc, inst_valid are driven combinationally from the head entry and count.

## Timing
- Reset (rst=0, immediate, no clock needed):
  - fetch_pc=RESET_PC, count=0, inflight=0, pointers=0.
  - inst_valid=0, inst=NOP, inst_pc=0, im_addr=RESET_PC[IM_AW-1:0].
- Cycle 0 = first cycle after rst deasserts: issue RESET_PC. Cycle 1: im_rdata captured. Cycle 2: inst_valid=1, inst_pc=RESET_PC.
- Steady state with deq_ready=1: one instruction per cycle, PCs strictly +4.
- Redirect asserted in cycle r:
  - Cycle r+1: inst_valid=0; target issued.
  - Cycle r+3: inst_valid=1 with inst_pc=target.
- Full (count=DEPTH): issue is stalled, fetch_pc holds, contents are retained indefinitely.
- Reset asserted mid-operation: all state is cleared asynchronously, and any in-flight response is lost.

## Test plan
- Startup: RESET_PC=0, IM words 0x00000093, 0x00100113, 0x00200193, ... with deq_ready=1 -> inst_valid rises in cycle 2 with inst_pc=0, inst=0x00000093; then PCs 4, 8, 0xC in consecutive cycles.
- Backpressure: deq_ready=0 from cycle 0 -> count reaches 4, fetch_pc stops at 0x10, im_addr holds 0x10. Raise deq_ready -> PCs 0, 4, 8, 0xC, 0x10 in order, none lost or duplicated.
- Redirect with response in flight: at count=2, inflight=1, pulse redirect with redirect_pc=0x200 -> next cycle count=0, inst_valid=0. First valid entry at r+3 has inst_pc=0x200. The stale response never appears.
- Misaligned redirect: redirect_pc=0x203 -> next im_addr=0x0200, first inst_pc=0x200.
- Wrap: redirect_pc=0xFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; im_addr sequence 0xFFF8, 0xFFFC, 0x0000.
- Async reset mid-stream: drop rst between clock edges while count=3 -> count=0, inst_valid=0 before the next edge. After release, fetch restarts at RESET_PC with first valid at cycle 2.
